// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO on the data-memory bus.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   chip_enable      : bus access valid this cycle
//   operation        : 1 = write, 0 = read
//   addr             : byte address; 16-byte window at BASE_ADDR
//   select_signal    : byte lanes, bit0 = data[7:0]
//   write_data       : store data
//   read_data        : combinational load data, 0 when not addressed
//   txd              : serial output, idle high
//   irq              : transmitter-drained interrupt (only with UART_TX_IRQ_EN)
// Registers: 0x0 TXDATA (W), 0x4 STATUS, 0x8 DIVISOR, 0xC IRQ_EN (only with UART_TX_IRQ_EN).
// Optional feature macro: UART_TX_IRQ_EN.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        chip_enable,
  input  logic        operation,
  input  logic [31:0] addr,
  input  logic [3:0]  select_signal,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        txd
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div;
  logic [15:0]   r_period;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          w_hit;
  logic          w_wr;
  logic [1:0]    w_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_bit_end;
  logic          w_pop;
  logic          w_clr;
  logic [31:0]   w_status;
  logic [31:0]   w_reg3;
  logic          w_unused;
  assign w_hit     = chip_enable && (addr[31:4] == BASE_ADDR[31:4]);
  assign w_idx     = addr[3:2];
  assign w_wr      = w_hit && operation;
  assign w_full    = r_count == CW'(FIFO_DEPTH);
  assign w_empty   = r_count == '0;
  assign w_push    = w_wr && w_idx == 2'd0 && select_signal[0];
  assign w_bit_end = r_cnt == r_period;
  // Pop when idle, or at the last clock of a stop bit so frames run back to back.
  assign w_pop     = !w_empty && (r_state == IDLE || (r_state == STOP && w_bit_end));
  assign w_clr     = w_wr && w_idx == 2'd1 && select_signal[0] && write_data[3];
  assign w_status  = {16'b0, 8'(r_count), 4'b0, r_ovf, w_empty, w_full, r_state != IDLE};
  assign read_data = (w_hit && !operation) ?
                     (w_idx == 2'd1 ? w_status :
                      w_idx == 2'd2 ? {16'b0, r_div} :
                      w_idx == 2'd3 ? w_reg3 : '0) : '0;
  assign txd       = r_txd;
  assign w_unused  = &{1'b0, addr[1:0], select_signal[3:2], write_data[31:16]};
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_div   <= DEFAULT_DIVISOR;
    end else begin
      // Fullness is judged before this edge's pop: a simultaneous pop frees no slot.
      if (w_push && !w_full) begin
        r_mem[r_wr] <= write_data[7:0];
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push && !w_full) - CW'(w_pop);
      // A dropped byte beats a same-cycle clear.
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
      if (w_wr && w_idx == 2'd2 && select_signal[0]) r_div[7:0] <= write_data[7:0];
      if (w_wr && w_idx == 2'd2 && select_signal[1]) r_div[15:8] <= write_data[15:8];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_txd    <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_period <= '0;
    end else begin
      case (r_state)
        IDLE, STOP: begin
          if (w_pop) begin
            // Divisor is latched per frame so mid-frame writes only affect the next one.
            r_shift  <= r_mem[r_rd];
            r_period <= r_div;
            r_cnt    <= '0;
            r_state  <= START;
            r_txd    <= 1'b0;
          end else if (r_state == STOP) begin
            if (w_bit_end) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else r_cnt <= r_cnt + 16'd1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_txd   <= r_shift[0];
          end else r_cnt <= r_cnt + 16'd1;
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
            end
          end else r_cnt <= r_cnt + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef UART_TX_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  assign w_reg3 = {31'b0, r_irq_en};
  assign irq    = r_irq;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_idx == 2'd3 && select_signal[0]) r_irq_en <= write_data[0];
      r_irq <= r_irq_en && w_empty && r_state == IDLE;
    end
  end
`else
  assign w_reg3 = '0;
`endif
endmodule
